// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: response owner tags
// and the default memory geometry.
package dmem_arb_pkg;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DMA = 1'b1
    } owner_e;

    localparam int DMEM_ADDR_W = 14;
    localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at LIMIT until cleared.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_r;

    // Count register: clear wins over increment, increment stops at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && (count_r < LIMIT_V)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the CPU memory stage (fixed priority)
// and a DMA requester with a starvation guard; routes read data to its issuer.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [DATA_W/8-1:0] cpu_req_we,
    input  logic [DATA_W-1:0]   cpu_req_wdata,
    output logic                cpu_rsp_valid,
    output logic [DATA_W-1:0]   cpu_rsp_data,
    input  logic                dma_req_valid,
    output logic                dma_req_ready,
    input  logic [ADDR_W-1:0]   dma_req_addr,
    input  logic [DATA_W/8-1:0] dma_req_we,
    input  logic [DATA_W-1:0]   dma_req_wdata,
    output logic                dma_rsp_valid,
    output logic [DATA_W-1:0]   dma_rsp_data,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic [31:0]         cpu_denied_cnt,
    input  logic                cnt_clr
);

    localparam int         BE_W     = DATA_W / 8;
    localparam logic [7:0] STARVE_V = 8'(STARVE_LIMIT);

    logic       grant_cpu_s;
    logic       grant_dma_s;
    logic       rd_grant_s;
    logic [7:0] wait_cnt_s;
    logic       rsp_pending_r;
    owner_e     rsp_owner_r;
    logic [31:0] denied_cnt_r;

    // Grant: DMA wins when the CPU is idle or the DMA has starved long enough
    always_comb begin
        grant_dma_s = 1'b0;
        grant_cpu_s = 1'b0;
        if (rst) begin
            grant_dma_s = 1'b0;
            grant_cpu_s = 1'b0;
        end else begin
            grant_dma_s = dma_req_valid & (~cpu_req_valid | (wait_cnt_s >= STARVE_V));
            grant_cpu_s = cpu_req_valid & ~grant_dma_s;
        end
    end

    assign cpu_req_ready = grant_cpu_s;
    assign dma_req_ready = grant_dma_s;

    // Memory port mux: the winner's request, or an all-zero idle port
    always_comb begin
        mem_en   = 1'b0;
        mem_addr = {ADDR_W{1'b0}};
        mem_we   = {BE_W{1'b0}};
        mem_din  = {DATA_W{1'b0}};
        if (grant_cpu_s) begin
            mem_en   = 1'b1;
            mem_addr = cpu_req_addr;
            mem_we   = cpu_req_we;
            mem_din  = cpu_req_wdata;
        end else if (grant_dma_s) begin
            mem_en   = 1'b1;
            mem_addr = dma_req_addr;
            mem_we   = dma_req_we;
            mem_din  = dma_req_wdata;
        end else begin
            mem_en   = 1'b0;
            mem_addr = {ADDR_W{1'b0}};
            mem_we   = {BE_W{1'b0}};
            mem_din  = {DATA_W{1'b0}};
        end
    end

    assign rd_grant_s = mem_en & (mem_we == {BE_W{1'b0}});

    sat_counter #(
        .WIDTH (8),
        .LIMIT (STARVE_LIMIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (dma_req_valid & ~grant_dma_s),
        .clr   (grant_dma_s | ~dma_req_valid),
        .count (wait_cnt_s)
    );

    // Tag the read in flight so next cycle's memory data reaches its issuer
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pending_r <= 1'b0;
            rsp_owner_r   <= OWNER_CPU;
        end else begin
            rsp_pending_r <= rd_grant_s;
            rsp_owner_r   <= grant_dma_s ? OWNER_DMA : OWNER_CPU;
        end
    end

    // A reset landing on the response cycle suppresses that response
    assign cpu_rsp_valid = rsp_pending_r & ~rst & (rsp_owner_r == OWNER_CPU);
    assign dma_rsp_valid = rsp_pending_r & ~rst & (rsp_owner_r == OWNER_DMA);
    assign cpu_rsp_data  = mem_dout;
    assign dma_rsp_data  = mem_dout;

    // CPU denied-cycle counter; clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            denied_cnt_r <= 32'd0;
        end else if (cnt_clr) begin
            denied_cnt_r <= 32'd0;
        end else if (cpu_req_valid && !grant_cpu_s) begin
            denied_cnt_r <= denied_cnt_r + 32'd1;
        end else begin
            denied_cnt_r <= denied_cnt_r;
        end
    end

    assign cpu_denied_cnt = denied_cnt_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a
// randomized run against a behavioural model of arbitration and memory.
module tb_dmem_port_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req_valid, cpu_req_ready;
    logic [AW-1:0] cpu_req_addr;
    logic [BW-1:0] cpu_req_we;
    logic [DW-1:0] cpu_req_wdata;
    logic          cpu_rsp_valid;
    logic [DW-1:0] cpu_rsp_data;
    logic          dma_req_valid, dma_req_ready;
    logic [AW-1:0] dma_req_addr;
    logic [BW-1:0] dma_req_we;
    logic [DW-1:0] dma_req_wdata;
    logic          dma_rsp_valid;
    logic [DW-1:0] dma_rsp_data;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic [31:0]   cpu_denied_cnt;
    logic          cnt_clr;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_addr(cpu_req_addr), .cpu_req_we(cpu_req_we),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_data(cpu_rsp_data),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
        .dma_req_addr(dma_req_addr), .dma_req_we(dma_req_we),
        .dma_req_wdata(dma_req_wdata),
        .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .cpu_denied_cnt(cpu_denied_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int a);
        if (a == 16) return 32'hDEAD_BEEF;
        return (32'(a) * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Synchronous single-port memory attached to the arbiter
    logic [31:0] mem [0:16383];
    bit          wr_seen [0:16383];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000)
                mem_dout <= wr_seen[mem_addr] ? mem[mem_addr] : init_word(int'(mem_addr));
            else begin
                mem[mem_addr] <= merge(wr_seen[mem_addr] ? mem[mem_addr] : init_word(int'(mem_addr)),
                                       mem_din, mem_we);
                wr_seen[mem_addr] <= 1'b1;
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    int          m_wait = 0;
    bit          m_pend = 1'b0;
    bit          m_owner_dma = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] ref_mem [int];

    bit          e_gcpu, e_gdma, e_en, e_rsp_cpu, e_rsp_dma;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_we;
    logic [DW-1:0] e_din;

    function automatic logic [31:0] ref_read(int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_eval();
        e_gdma = !rst && dma_req_valid && (!cpu_req_valid || m_wait >= LIMIT);
        e_gcpu = !rst && cpu_req_valid && !e_gdma;
        e_en   = e_gcpu || e_gdma;
        e_addr = e_gcpu ? cpu_req_addr  : (e_gdma ? dma_req_addr  : 14'd0);
        e_we   = e_gcpu ? cpu_req_we    : (e_gdma ? dma_req_we    : 4'd0);
        e_din  = e_gcpu ? cpu_req_wdata : (e_gdma ? dma_req_wdata : 32'd0);
        e_rsp_cpu = !rst && m_pend && !m_owner_dma;
        e_rsp_dma = !rst && m_pend && m_owner_dma;
    endtask

    task automatic model_commit();
        if (rst) begin
            m_wait = 0; m_pend = 1'b0; m_owner_dma = 1'b0; m_cnt = 32'd0;
        end else begin
            if (cnt_clr) m_cnt = 32'd0;
            else if (cpu_req_valid && !e_gcpu) m_cnt = m_cnt + 32'd1;
            if (e_gdma || !dma_req_valid) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
            m_pend = 1'b0;
            if (e_en) begin
                if (e_we == 4'b0000) begin
                    m_pend = 1'b1;
                    m_owner_dma = e_gdma;
                    m_rdata = ref_read(int'(e_addr));
                end else begin
                    ref_mem[int'(e_addr)] = merge(ref_read(int'(e_addr)), e_din, e_we);
                end
            end
        end
    endtask

    task automatic settle();
        model_eval();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic idle();
        cpu_req_valid = 1'b0; cpu_req_addr = 14'd0; cpu_req_we = 4'd0; cpu_req_wdata = 32'd0;
        dma_req_valid = 1'b0; dma_req_addr = 14'd0; dma_req_we = 4'd0; dma_req_wdata = 32'd0;
        cnt_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rst = 1'b1; cpu_req_valid = 1'b1; dma_req_valid = 1'b1;
        settle();
        n_checks++;
        if ({cpu_req_ready, dma_req_ready, mem_en} !== 3'b000) begin
            n_fail++; $display("FAIL reset_grants: got %b expected 000", {cpu_req_ready, dma_req_ready, mem_en});
        end
        advance();
        settle();
        n_checks++;
        if ({cpu_rsp_valid, dma_rsp_valid, cpu_denied_cnt} !== 34'd0) begin
            n_fail++; $display("FAIL reset_state: got rsp %b%b cnt %0d expected 00 cnt 0", cpu_rsp_valid, dma_rsp_valid, cpu_denied_cnt);
        end
        advance();
        rst = 1'b0; idle();
        settle(); advance();
    endtask

    task automatic test_cpu_read();
        idle();
        cpu_req_valid = 1'b1; cpu_req_addr = 14'h0010;
        settle();
        n_checks++;
        if ({cpu_req_ready, mem_en, mem_addr} !== {1'b1, 1'b1, 14'h0010}) begin
            n_fail++; $display("FAIL cpu_read_grant: got rdy %b en %b addr %h expected 1 1 0010", cpu_req_ready, mem_en, mem_addr);
        end
        advance();
        idle();
        settle();
        n_checks++;
        if ({cpu_rsp_valid, dma_rsp_valid, cpu_rsp_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_fail++; $display("FAIL cpu_read_rsp: got %b %b %h expected 1 0 deadbeef", cpu_rsp_valid, dma_rsp_valid, cpu_rsp_data);
        end
        advance();
    endtask

    task automatic test_starvation();
        idle(); cnt_clr = 1'b1;
        settle(); advance();
        for (int k = 0; k < 27; k++) begin
            idle();
            cpu_req_valid = 1'b1; cpu_req_addr = 14'($urandom_range(0, 1023));
            dma_req_valid = 1'b1; dma_req_addr = 14'h0020;
            settle();
            n_checks++;
            if ({cpu_req_ready, dma_req_ready} !== {(k % 9) != 8, (k % 9) == 8}) begin
                n_fail++; $display("FAIL starve_grant[%0d]: got cpu %b dma %b expected dma=%b", k, cpu_req_ready, dma_req_ready, (k % 9) == 8);
            end
            advance();
        end
        idle();
        settle();
        n_checks++;
        if (cpu_denied_cnt !== 32'd3) begin
            n_fail++; $display("FAIL starve_denied_cnt: got %0d expected 3", cpu_denied_cnt);
        end
        advance();
    endtask

    task automatic test_cnt_clr();
        for (int k = 0; k < 18; k++) begin
            idle();
            cpu_req_valid = 1'b1; cpu_req_addr = 14'h0040;
            dma_req_valid = 1'b1; dma_req_addr = 14'h0041;
            cnt_clr = (k == 8);
            settle();
            if (k == 9) begin
                n_checks++;
                if (cpu_denied_cnt !== 32'd0) begin
                    n_fail++; $display("FAIL clr_with_inc: got %0d expected 0", cpu_denied_cnt);
                end
            end
            advance();
        end
        idle();
        settle();
        n_checks++;
        if (cpu_denied_cnt !== 32'd1) begin
            n_fail++; $display("FAIL clr_resume: got %0d expected 1", cpu_denied_cnt);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            idle();
            case (c)
                0: begin cpu_req_valid = 1'b1; cpu_req_addr = 14'h0100; end
                1: begin dma_req_valid = 1'b1; dma_req_addr = 14'h0101; end
                2: begin cpu_req_valid = 1'b1; cpu_req_addr = 14'h0102;
                         cpu_req_we = 4'b0011; cpu_req_wdata = 32'h1234_ABCD; end
                4: begin cpu_req_valid = 1'b1; cpu_req_addr = 14'h0102; end
                default: ;
            endcase
            settle();
            n_checks++;
            if (mem_we !== ((c == 2) ? 4'b0011 : 4'b0000)) begin
                n_fail++; $display("FAIL b2b_mem_we[%0d]: got %b", c, mem_we);
            end
            n_checks++;
            if ({cpu_rsp_valid, dma_rsp_valid} !== {(c == 1) || (c == 5), c == 2}) begin
                n_fail++; $display("FAIL b2b_rsp_tag[%0d]: got cpu %b dma %b", c, cpu_rsp_valid, dma_rsp_valid);
            end
            if (c == 1 || c == 2 || c == 5) begin
                logic [31:0] want;
                want = (c == 1) ? init_word(32'h100) : (c == 2) ? init_word(32'h101)
                     : {init_word(32'h102) >> 16, 16'hABCD};
                n_checks++;
                if (((c == 2) ? dma_rsp_data : cpu_rsp_data) !== want) begin
                    n_fail++; $display("FAIL b2b_rsp_data[%0d]: got %h expected %h", c, (c == 2) ? dma_rsp_data : cpu_rsp_data, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_cpu_drop();
        idle(); settle(); advance();
        for (int k = 0; k < 15; k++) begin
            idle();
            cpu_req_valid = (k != 5); cpu_req_addr = 14'h0200;
            dma_req_valid = 1'b1; dma_req_addr = 14'h0300;
            settle();
            n_checks++;
            if (dma_req_ready !== ((k == 5) || (k == 14))) begin
                n_fail++; $display("FAIL cpu_drop_dma_grant[%0d]: got %b expected %b", k, dma_req_ready, (k == 5) || (k == 14));
            end
            advance();
        end
    endtask

    task automatic test_reset_after_grant();
        idle();
        dma_req_valid = 1'b1; dma_req_addr = 14'h0030;
        settle();
        n_checks++;
        if (dma_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rag_grant: got %b expected 1", dma_req_ready);
        end
        advance();
        rst = 1'b1; cpu_req_valid = 1'b1; dma_req_valid = 1'b1;
        settle();
        n_checks++;
        if ({cpu_req_ready, dma_req_ready, mem_en, dma_rsp_valid, cpu_rsp_valid} !== 5'b00000) begin
            n_fail++; $display("FAIL rag_in_reset: got %b expected 00000", {cpu_req_ready, dma_req_ready, mem_en, dma_rsp_valid, cpu_rsp_valid});
        end
        advance();
        rst = 1'b0; idle();
        settle();
        n_checks++;
        if ({dma_rsp_valid, cpu_rsp_valid, cpu_denied_cnt} !== 34'd0) begin
            n_fail++; $display("FAIL rag_after: got rsp %b%b cnt %0d expected 00 0", dma_rsp_valid, cpu_rsp_valid, cpu_denied_cnt);
        end
        advance();
    endtask

    task automatic test_random();
        bit dma_hold;
        logic [54:0] got_v, exp_v;
        dma_hold = 1'b0;
        idle();
        for (int i = 0; i < 600; i++) begin
            cpu_req_valid = ($urandom_range(0, 3) != 0);
            cpu_req_addr  = 14'($urandom_range(0, 31));
            cpu_req_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            cpu_req_wdata = $urandom;
            if (!dma_hold) begin
                dma_req_valid = ($urandom_range(0, 2) != 0);
                dma_req_addr  = 14'($urandom_range(0, 31));
                dma_req_we    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                dma_req_wdata = $urandom;
            end
            cnt_clr = ($urandom_range(0, 29) == 0);
            settle();
            got_v = {cpu_req_ready, dma_req_ready, mem_en, mem_addr, mem_we, mem_din, cpu_rsp_valid, dma_rsp_valid};
            exp_v = {e_gcpu, e_gdma, e_en, e_addr, e_we, e_din, e_rsp_cpu, e_rsp_dma};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL rand_port[%0d]: got %h expected %h", i, got_v, exp_v);
            end
            if (e_rsp_cpu || e_rsp_dma) begin
                n_checks++;
                if ((e_rsp_dma ? dma_rsp_data : cpu_rsp_data) !== m_rdata) begin
                    n_fail++; $display("FAIL rand_rsp_data[%0d]: got %h expected %h", i, e_rsp_dma ? dma_rsp_data : cpu_rsp_data, m_rdata);
                end
            end
            n_checks++;
            if (cpu_denied_cnt !== m_cnt) begin
                n_fail++; $display("FAIL rand_denied_cnt[%0d]: got %0d expected %0d", i, cpu_denied_cnt, m_cnt);
            end
            dma_hold = dma_req_valid && !e_gdma;
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_cpu_read();
        test_starvation();
        test_cnt_clr();
        test_back_to_back();
        test_cpu_drop();
        test_reset_after_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
